// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//
// Instruction fetch and decode front end. It fetches one 16-bit instruction
// word from a synchronous instruction memory (one-cycle read latency),
// decodes it into a one-hot instruction class plus register and immediate
// fields, and holds the decoded result until the execution FSM retires it.
// On retirement the PC either advances by one or is redirected to the jump
// target. NOP and illegal opcodes retire on their own after one cycle; the
// illegal opcode also sets a sticky flag. HALT freezes the unit until reset.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   imem_addr/imem_rd instruction memory read address and read strobe
//   imem_data         read data, valid in the cycle after imem_rd
//   nextInstruction   retire pulse from the execution FSM
//   enableJUMP,
//   enableCMPJUMP     redirect the PC to target at retirement
//   alu..cmpJump      one-hot instruction class (registered)
//   rd, rs1, rs2,
//   funct, target     decoded instruction fields
//   pc                current program counter
//   instr_valid       decoded outputs valid and awaiting retirement
//   halted, illegal   halt indicator; sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [IW-1:0] imem_data,
  input  logic          nextInstruction,
  input  logic          enableJUMP,
  input  logic          enableCMPJUMP,
  output logic          alu,
  output logic          ld,
  output logic          st,
  output logic          jump,
  output logic          cmpJump,
  output logic [2:0]    rd,
  output logic [2:0]    rs1,
  output logic [2:0]    rs2,
  output logic [3:0]    funct,
  output logic [AW-1:0] target,
  output logic [AW-1:0] pc,
  output logic          instr_valid,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DECODED,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_ALU     = 3'b001,
    OP_LD      = 3'b010,
    OP_ST      = 3'b011,
    OP_JUMP    = 3'b100,
    OP_CMPJUMP = 3'b101,
    OP_ILLEGAL = 3'b110,
    OP_HALT    = 3'b111
  } opcode_e;

  typedef struct packed {
    logic alu;
    logic ld;
    logic st;
    logic jump;
    logic cmp_jump;
  } class_t;

  localparam logic [AW-1:0] PC_INC = AW'(1);

  state_e        state_q,   state_d;
  logic [AW-1:0] pc_q,      pc_d;
  logic [IW-1:0] ir_q,      ir_d;
  logic          imem_rd_q, imem_rd_d;
  class_t        cls_q,     cls_d;
  logic          valid_q,   valid_d;
  logic          halted_q,  halted_d;
  logic          illegal_q, illegal_d;

  opcode_e data_op;
  opcode_e ir_op;

  assign data_op = opcode_e'(imem_data[IW-1 -: 3]);
  assign ir_op   = opcode_e'(ir_q[IW-1 -: 3]);

  function automatic class_t decode_class(input opcode_e op);
    class_t c;
    c = '0;
    case (op)
      OP_ALU:     c.alu      = 1'b1;
      OP_LD:      c.ld       = 1'b1;
      OP_ST:      c.st       = 1'b1;
      OP_JUMP:    c.jump     = 1'b1;
      OP_CMPJUMP: c.cmp_jump = 1'b1;
      default:    c          = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imem_rd_d = imem_rd_q;
    cls_d     = cls_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        // The read strobe is a flop, so it is cleared while reset is held.
        // Straight out of reset it is raised here on the first edge; every
        // later entry into FETCH raises it on the way in, keeping the loop
        // at three cycles per instruction.
        if (imem_rd_q) begin
          imem_rd_d = 1'b0;
          state_d   = S_WAIT;
        end else begin
          imem_rd_d = 1'b1;
        end
      end

      S_WAIT: begin
        ir_d = imem_data;
        if (data_op == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_DECODED;
          cls_d   = decode_class(data_op);
          valid_d = |cls_d;
        end
      end

      S_DECODED: begin
        if (!valid_q) begin
          // NOP or illegal opcode: nothing to retire, advance on our own.
          pc_d      = pc_q + PC_INC;
          state_d   = S_FETCH;
          imem_rd_d = 1'b1;
          if (ir_op == OP_ILLEGAL) begin
            illegal_d = 1'b1;
          end
        end else if (nextInstruction) begin
          pc_d      = (enableJUMP || enableCMPJUMP) ? target : pc_q + PC_INC;
          cls_d     = '0;
          valid_d   = 1'b0;
          state_d   = S_FETCH;
          imem_rd_d = 1'b1;
        end
      end

      S_HALT: begin
        // Frozen until reset.
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      imem_rd_q <= 1'b0;
      cls_q     <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imem_rd_q <= imem_rd_d;
      cls_q     <= cls_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = imem_rd_q;
  assign pc          = pc_q;

  assign alu         = cls_q.alu;
  assign ld          = cls_q.ld;
  assign st          = cls_q.st;
  assign jump        = cls_q.jump;
  assign cmpJump     = cls_q.cmp_jump;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

  assign rd          = ir_q[12:10];
  assign rs1         = ir_q[9:7];
  assign rs2         = ir_q[6:4];
  assign funct       = ir_q[3:0];
  assign target      = AW'(ir_q[7:0]);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decode
//
// Scoreboard bench for instr_fetch_decode. A program-level model walks the
// instruction memory (pc, sticky illegal flag, redirect rules) and pushes the
// fetch, decode and halt events it expects into queues; an independent
// monitor pops and compares whenever the DUT shows a fetch strobe, a newly
// valid decode, or the halt indicator. Directed programs cover the named
// scenarios (ALU/JUMP/CMPJUMP/NOP/illegal/HALT, PC wrap, reset in WAIT and
// HALT); randomized programs and retire timing cover the rest.
// -----------------------------------------------------------------------------
module tb_instr_fetch_decode;

  localparam int IW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [IW-1:0] imem_data;
  logic          nextInstruction;
  logic          enableJUMP;
  logic          enableCMPJUMP;
  logic          alu, ld, st, jump, cmpJump;
  logic [2:0]    rd, rs1, rs2;
  logic [3:0]    funct;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          instr_valid;
  logic          halted;
  logic          illegal;

  always #5 clk = ~clk;

  instr_fetch_decode #(.IW(IW), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .imem_data       (imem_data),
    .nextInstruction (nextInstruction),
    .enableJUMP      (enableJUMP),
    .enableCMPJUMP   (enableCMPJUMP),
    .alu             (alu),
    .ld              (ld),
    .st              (st),
    .jump            (jump),
    .cmpJump         (cmpJump),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .funct           (funct),
    .target          (target),
    .pc              (pc),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .illegal         (illegal)
  );

  // Synchronous instruction memory: data appears the cycle after the strobe.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  typedef struct {
    int addr;
    bit ill;
  } fetch_t;

  typedef struct {
    logic [4:0] cls;    // {alu, ld, st, jump, cmpJump}
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] funct;
    logic [7:0] target;
  } dec_t;

  fetch_t fetch_q[$];
  dec_t   dec_q[$];
  int     halt_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int         m_pc;
  bit         m_ill;
  logic [1:0] dir_en [0:7];   // {enableJUMP, enableCMPJUMP} per retirement

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Field extraction straight from the instruction format.
  function automatic dec_t model_decode(input int w);
    dec_t d;
    int   op;
    op       = (w >> 13) % 8;
    d.cls    = 5'(5'd16 >> (op - 1));
    d.rd     = 3'((w >> 10) % 8);
    d.rs1    = 3'((w >> 7) % 8);
    d.rs2    = 3'((w >> 4) % 8);
    d.funct  = 4'(w % 16);
    d.target = 8'(w % 256);
    return d;
  endfunction

  function automatic void push_fetch();
    fetch_q.push_back('{addr: m_pc, ill: m_ill});
  endfunction

  // ---------------------------------------------------------------- monitor
  bit valid_seen = 1'b0;
  bit halt_seen  = 1'b0;
  int halt_pc    = 0;

  always @(negedge clk) begin
    fetch_t f;
    dec_t   d;
    int     h;
    if (reset) begin
      valid_seen = 1'b0;
      halt_seen  = 1'b0;
    end else begin
      if (imem_rd) begin
        check("fetch_expected", 32'(fetch_q.size() > 0), 32'd1);
        if (fetch_q.size() > 0) begin
          f = fetch_q.pop_front();
          check("fetch_addr", 32'(imem_addr), f.addr);
          check("fetch_pc", 32'(pc), f.addr);
          check("fetch_illegal", 32'(illegal), 32'(f.ill));
        end
      end

      if (instr_valid && !valid_seen) begin
        check("decode_expected", 32'(dec_q.size() > 0), 32'd1);
        if (dec_q.size() > 0) begin
          d = dec_q.pop_front();
          check("dec_class", 32'({alu, ld, st, jump, cmpJump}), 32'(d.cls));
          check("dec_fields", 32'({rd, rs1, rs2, funct}), 32'({d.rd, d.rs1, d.rs2, d.funct}));
          check("dec_target", 32'(target), 32'(d.target));
        end
      end
      valid_seen = instr_valid;

      if (!instr_valid) begin
        check("class_idle", 32'({alu, ld, st, jump, cmpJump}), 32'd0);
      end

      if (halted && !halt_seen) begin
        check("halt_expected", 32'(halt_q.size() > 0), 32'd1);
        if (halt_q.size() > 0) begin
          h       = halt_q.pop_front();
          halt_pc = h;
          check("halt_pc_entry", 32'(pc), h);
        end
      end
      if (halted) begin
        check("halt_pc_frozen", 32'(pc), halt_pc);
      end
      halt_seen = halted;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic quiet();
    nextInstruction = 1'b0;
    enableJUMP      = 1'b0;
    enableCMPJUMP   = 1'b0;
  endtask

  // Random activity on the retire inputs; only used while the DUT cannot
  // be retiring, so it must have no effect.
  task automatic drive_noise();
    nextInstruction = 1'($urandom_range(0, 1));
    enableJUMP      = 1'($urandom_range(0, 1));
    enableCMPJUMP   = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_check();
    reset = 1'b1;
    #1;
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_rd", 32'(imem_rd), 32'd0);
    check("rst_class", 32'({alu, ld, st, jump, cmpJump}), 32'd0);
    check("rst_fields", 32'({rd, rs1, rs2, funct, target}), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("fetch_q_drained", fetch_q.size(), 32'd0);
    check("dec_q_drained", dec_q.size(), 32'd0);
    check("halt_q_drained", halt_q.size(), 32'd0);
    fetch_q.delete();
    dec_q.delete();
    halt_q.delete();
    quiet();
  endtask

  task automatic release_reset();
    m_pc  = 0;
    m_ill = 1'b0;
    push_fetch();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_fetch_rd", 32'(imem_rd), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      int r;
      int op;
      r = $urandom_range(0, 99);
      if (r < 8)       op = 0;
      else if (r < 11) op = 6;
      else if (r < 13) op = 7;
      else             op = $urandom_range(1, 5);
      mem[i] = 16'((op << 13) | $urandom_range(0, 8191));
    end
  endtask

  // Walk the program from the model pc. Ends (with reset) at HALT, or once
  // n_ret instructions have retired and the next one is sitting decoded.
  task automatic run_phase(input int n_ret, input bit directed);
    int         retired;
    int         w;
    int         op;
    int         dly;
    int         cyc;
    logic [1:0] en;
    retired = 0;
    for (int step = 0; step < 1000; step++) begin
      w  = int'(mem[m_pc]);
      op = (w >> 13) % 8;

      if (op == 7) begin
        halt_q.push_back(m_pc);
        cyc = 0;
        do begin
          @(negedge clk);
          drive_noise();
          cyc++;
        end while (!halted && cyc < 30);
        check("wait_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("halt_rd_idle", 32'(imem_rd), 32'd0);
          drive_noise();
        end
        #2;
        reset_check();
        return;
      end

      if (op == 0 || op == 6) begin
        if (op == 6) m_ill = 1'b1;
        m_pc = (m_pc + 1) % 256;
        push_fetch();
        continue;
      end

      dec_q.push_back(model_decode(w));
      cyc = 0;
      do begin
        @(negedge clk);
        if (!instr_valid) drive_noise();
        cyc++;
      end while (!instr_valid && cyc < 30);
      check("wait_instr_valid", 32'(instr_valid), 32'd1);
      quiet();
      if (!instr_valid || retired == n_ret) begin
        #2;
        reset_check();
        return;
      end

      en  = directed ? dir_en[retired] : 2'($urandom_range(0, 3));
      dly = directed ? 0 : $urandom_range(0, 2);
      repeat (dly) @(negedge clk);
      nextInstruction = 1'b1;
      enableJUMP      = en[1];
      enableCMPJUMP   = en[0];
      m_pc = (en != 2'b00) ? (w % 256) : (m_pc + 1) % 256;
      push_fetch();
      @(negedge clk);
      quiet();
      retired++;
    end
    #2;
    reset_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    quiet();
    fill_random();
    #12;
    reset_check();

    // ALU at 0, JUMP to 0x42, CMPJUMP not taken, NOP, illegal, HALT.
    mem[8'h00] = 16'h2000;
    mem[8'h01] = 16'h8042;
    mem[8'h42] = 16'hA010;
    mem[8'h43] = 16'h0000;
    mem[8'h44] = 16'hC000;
    mem[8'h45] = 16'hE000;
    dir_en = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    release_reset();
    run_phase(8, 1'b1);

    // Reset while the fetch is outstanding (WAIT), then restart at 0.
    release_reset();
    @(negedge clk);
    check("wait_no_strobe", 32'(imem_rd), 32'd0);
    #2;
    reset_check();

    // PC wrap: jump to 0xFF, retire an ALU there without redirect.
    fill_random();
    mem[8'h00] = 16'h80FF;
    mem[8'hFF] = 16'h2000;
    dir_en = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    release_reset();
    run_phase(2, 1'b1);

    for (int p = 0; p < 12; p++) begin
      fill_random();
      release_reset();
      run_phase($urandom_range(5, 40), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter: IW, default 16, instruction word width in bits; fixed at 16 for this revision.
REQ-002 Parameter: AW, default 8, program counter and instruction address width in bits.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: imem_addr  output  AW  instruction memory read address.
REQ-006 Port: imem_rd  output  1  instruction memory read strobe; data returns exactly one cycle later.
REQ-007 Port: imem_data  input  IW  instruction memory read data; valid in the cycle after imem_rd.
REQ-008 Port: nextInstruction  input  1  FSM pulse indicating the current instruction has retired.
REQ-009 Port: enableJUMP, enableCMPJUMP  input  1 each  FSM indication that the retiring instruction redirects the PC.
REQ-010 Port: alu, ld, st, jump, cmpJump  output  1 each  one-hot instruction class; at most one is high.
REQ-011 Port: rd, rs1, rs2  output  3 each  register fields, rd=IR[12:10], rs1=IR[9:7], rs2=IR[6:4].
REQ-012 Port: funct  output  4  ALU function field, IR[3:0].
REQ-013 Port: target  output  AW  jump target, IR[7:0].
REQ-014 Port: pc  output  AW  current program counter.
REQ-015 Port: instr_valid  output  1  high while decoded outputs are valid and awaiting retirement.
REQ-016 Port: halted, illegal  output  1 each  halt state indicator; sticky illegal-opcode flag.

Function
REQ-017 Opcode is IR[15:13]: 000 NOP, 001 ALU, 010 LD, 011 ST, 100 JUMP, 101 CMPJUMP, 110 illegal, 111 HALT.
REQ-018 State machine states: FETCH, WAIT, DECODED, HALT.
REQ-019 FETCH: imem_rd=1 and imem_addr=pc for one cycle; next state is WAIT.
REQ-020 WAIT: IR captures imem_data at the end of the cycle; next state is DECODED, or HALT for opcode 111.
REQ-021 DECODED with opcode 001-101: instr_valid=1 and the matching class output is 1; the state holds until nextInstruction=1.
REQ-022 Class outputs, instr_valid and fields are registered; class outputs are 0 in every state other than DECODED.
REQ-023 Retirement (DECODED and nextInstruction=1): if enableJUMP or enableCMPJUMP is 1 in that cycle, pc<=target; otherwise pc<=pc+1; next state is FETCH.
REQ-024 pc increment wraps modulo 2^AW, so 0xFF becomes 0x00.
REQ-025 NOP (000) in DECODED: instr_valid=0 and no class output; auto-advance after one cycle with pc<=pc+1 and next state FETCH.
REQ-026 Illegal opcode (110): handled as NOP; additionally illegal<=1, which stays set until reset.
REQ-027 HALT: halted=1, imem_rd=0, pc frozen, all inputs ignored; the state is left only by reset.
REQ-028 nextInstruction, enableJUMP and enableCMPJUMP are ignored outside DECODED.
REQ-029 If enableJUMP and enableCMPJUMP are both high at retirement, pc<=target (the same as either alone).
REQ-030 Minimum loop is 3 cycles per instruction: FETCH, WAIT, DECODED, with retirement in the first DECODED cycle.

Reset
REQ-031 When reset=1: state=FETCH; pc=0; IR=0; imem_rd=0; imem_addr=0; all class outputs=0; instr_valid=0; halted=0; illegal=0.
REQ-032 Reset takes effect immediately in any state, including mid-fetch and HALT, and discards any pending instruction.
REQ-033 First imem_rd=1 with imem_addr=0 occurs in the first rising edge cycle after reset deasserts.

Verification
REQ-034 Reset release; mem[0]=0x2000 (ALU); pulse nextInstruction in the first DECODED cycle -> imem_rd at addr 0; alu=1 and instr_valid=1 two cycles later; after the pulse pc=1 and the next fetch is at addr 1.
REQ-035 mem[1]=0x8042 (JUMP, target 0x42); nextInstruction with enableJUMP=1 -> jump=1 during DECODED; pc=0x42 after retirement; next imem_addr=0x42.
REQ-036 mem[0x42]=0xA010 (CMPJUMP, target 0x10); nextInstruction with enableCMPJUMP=0 -> cmpJump=1; pc=0x43 after retirement (branch not taken).
REQ-037 mem[0x43]=0x0000, mem[0x44]=0xC000, mem[0x45]=0xE000 -> NOP auto-advances; illegal=1 at 0x44 and stays 1; halted=1 at 0x45, pc stays 0x45, imem_rd stays 0 for 10 cycles despite nextInstruction pulses.
REQ-038 pc=0xFF holding ALU instruction; nextInstruction with no redirect -> pc=0x00 (wrap).
REQ-039 Assert reset during WAIT and during HALT -> all outputs return to reset values immediately; on release, fetch restarts at addr 0.
